// File: rtl/bcd_accum_ctrl.sv
// rtl/bcd_accum_ctrl.sv - three-digit BCD accumulator with a digit-serial add sequencer
module bcd_accum_ctrl #(
    parameter bit SATURATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_clr,
    input  logic [7:0] in_data,
    output logic [3:0] acc_d2,
    output logic [3:0] acc_d1,
    output logic [3:0] acc_d0,
    output logic       done,
    output logic       err,
    output logic       ovf
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD0 = 3'd1,
        ADD1 = 3'd2,
        ADD2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] op;
    logic       carry;

    logic       accept;
    logic       digits_ok;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic       slice_cin;
    logic [4:0] slice_sum;
    logic       slice_cout;
    logic [3:0] slice_digit;

    assign in_ready  = (state == IDLE);
    assign done      = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign digits_ok = (in_data[7:4] <= 4'd9) && (in_data[3:0] <= 4'd9);

    // One BCD digit adder, steered to the digit selected by the current add state.
    always_comb begin
        slice_a   = acc_d0;
        slice_b   = op[3:0];
        slice_cin = 1'b0;
        case (state)
            ADD1: begin
                slice_a   = acc_d1;
                slice_b   = op[7:4];
                slice_cin = carry;
            end
            ADD2: begin
                slice_a   = acc_d2;
                slice_b   = 4'd0;
                slice_cin = carry;
            end
            default: begin
            end
        endcase
        slice_sum   = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};
        slice_cout  = (slice_sum > 5'd9);
        slice_digit = slice_cout ? (slice_sum[3:0] + 4'd6) : slice_sum[3:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_clr) begin
                        state_next = DONE;
                    end else if (digits_ok) begin
                        state_next = ADD0;
                    end
                end
            end
            ADD0:    state_next = ADD1;
            ADD1:    state_next = ADD2;
            ADD2:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= 8'h00;
            carry  <= 1'b0;
            acc_d2 <= 4'd0;
            acc_d1 <= 4'd0;
            acc_d0 <= 4'd0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            err   <= accept && !in_clr && !digits_ok;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_clr) begin
                            acc_d2 <= 4'd0;
                            acc_d1 <= 4'd0;
                            acc_d0 <= 4'd0;
                            ovf    <= 1'b0;
                            carry  <= 1'b0;
                        end else if (digits_ok) begin
                            op    <= in_data;
                            carry <= 1'b0;
                        end
                    end
                end
                ADD0: begin
                    acc_d0 <= slice_digit;
                    carry  <= slice_cout;
                end
                ADD1: begin
                    acc_d1 <= slice_digit;
                    carry  <= slice_cout;
                end
                ADD2: begin
                    carry <= 1'b0;
                    // A carry out of the hundreds digit means the total passed 999.
                    if (slice_cout) begin
                        ovf <= 1'b1;
                        if (SATURATE) begin
                            acc_d2 <= 4'd9;
                            acc_d1 <= 4'd9;
                            acc_d0 <= 4'd9;
                        end else begin
                            acc_d2 <= slice_digit;
                        end
                    end else begin
                        acc_d2 <= slice_digit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_accum_ctrl.sv
// tb/tb_bcd_accum_ctrl.sv - bench for bcd_accum_ctrl, wrapping and saturating builds side by side
module tb_bcd_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_clr = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       rdy0, done0, err0, ovf0;
    logic       rdy1, done1, err1, ovf1;
    logic [3:0] a2_0, a1_0, a0_0;
    logic [3:0] a2_1, a1_1, a0_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_accum_ctrl #(.SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_clr(in_clr),
        .in_data(in_data), .acc_d2(a2_0), .acc_d1(a1_0), .acc_d0(a0_0),
        .done(done0), .err(err0), .ovf(ovf0)
    );

    bcd_accum_ctrl #(.SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_clr(in_clr),
        .in_data(in_data), .acc_d2(a2_1), .acc_d1(a1_1), .acc_d0(a0_1),
        .done(done1), .err(err1), .ovf(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        return 32'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Reference model: totals as integers, busy time as a countdown of cycles until idle.
    int  m_cnt = 0;
    int  m_tot[2];
    bit  m_ovf[2];
    bit  m_err = 1'b0;
    bit  model_live = 1'b0;
    int  m_sum;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_err = 1'b0;
            for (int s = 0; s < 2; s++) begin
                m_tot[s] = 0;
                m_ovf[s] = 1'b0;
            end
            model_live = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
            end else if (in_valid) begin
                if (in_clr) begin
                    m_cnt = 1;
                    for (int s = 0; s < 2; s++) begin
                        m_tot[s] = 0;
                        m_ovf[s] = 1'b0;
                    end
                end else if (in_data[7:4] > 4'd9 || in_data[3:0] > 4'd9) begin
                    m_err = 1'b1;
                end else begin
                    m_cnt = 4;
                    for (int s = 0; s < 2; s++) begin
                        m_sum = m_tot[s] + 10 * int'(in_data[7:4]) + int'(in_data[3:0]);
                        if (m_sum > 999) begin
                            m_ovf[s] = 1'b1;
                            m_tot[s] = (s == 1) ? 999 : m_sum - 1000;
                        end else begin
                            m_tot[s] = m_sum;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("in_ready_wrap", 32'(rdy0), 32'(m_cnt == 0));
            chk("in_ready_sat", 32'(rdy1), 32'(m_cnt == 0));
            chk("done_wrap", 32'(done0), 32'(m_cnt == 1));
            chk("done_sat", 32'(done1), 32'(m_cnt == 1));
            chk("err_wrap", 32'(err0), 32'(m_err));
            chk("err_sat", 32'(err1), 32'(m_err));
            if (m_cnt <= 1) begin
                chk("acc_wrap", {20'b0, a2_0, a1_0, a0_0}, to_bcd(m_tot[0]));
                chk("acc_sat", {20'b0, a2_1, a1_1, a0_1}, to_bcd(m_tot[1]));
                chk("ovf_wrap", 32'(ovf0), 32'(m_ovf[0]));
                chk("ovf_sat", 32'(ovf1), 32'(m_ovf[1]));
            end
        end
    end

    task automatic issue(input logic clr, input logic [7:0] d);
        int b;
        b = 0;
        while (!rdy0 && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (!rdy0) chk("ready_timeout", 32'(rdy0), 32'd1);
        in_valid = 1'b1;
        in_clr   = clr;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_clr   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_wait);
        int n;
        n = 0;
        while (!done0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n), 32'(exp_wait));
    endtask

    initial begin
        int last;
        int n_acc;
        bit acc_now;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(rdy0), 32'd1);
        chk("reset_acc", {20'b0, a2_0, a1_0, a0_0}, 32'h000);
        chk("reset_ovf", 32'(ovf0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_err", 32'(err0), 32'd0);

        issue(1'b0, 8'h47);
        wait_done("latency_47", 3);
        chk("acc_after_47", {20'b0, a2_0, a1_0, a0_0}, 32'h047);
        issue(1'b0, 8'h38);
        wait_done("latency_38", 3);
        chk("acc_after_38", {20'b0, a2_0, a1_0, a0_0}, 32'h085);
        chk("ovf_after_38", 32'(ovf0), 32'd0);
        @(negedge clk);

        issue(1'b0, 8'h3A);
        chk("err_pulse_3a", 32'(err0), 32'd1);
        chk("no_done_3a", 32'(done0), 32'd0);
        chk("ready_3a", 32'(rdy0), 32'd1);
        chk("acc_kept_3a", {20'b0, a2_0, a1_0, a0_0}, 32'h085);
        @(negedge clk);
        chk("err_single_cycle", 32'(err0), 32'd0);

        issue(1'b1, 8'h00);
        wait_done("latency_clear", 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 8'h99);
            wait_done("latency_99", 3);
            @(negedge clk);
        end
        issue(1'b0, 8'h05);
        wait_done("latency_05", 3);
        chk("acc_995_wrap", {20'b0, a2_0, a1_0, a0_0}, 32'h995);
        chk("acc_995_sat", {20'b0, a2_1, a1_1, a0_1}, 32'h995);
        @(negedge clk);
        issue(1'b0, 8'h07);
        wait_done("latency_07", 3);
        chk("acc_wrap_002", {20'b0, a2_0, a1_0, a0_0}, 32'h002);
        chk("ovf_wrap_set", 32'(ovf0), 32'd1);
        chk("acc_sat_999", {20'b0, a2_1, a1_1, a0_1}, 32'h999);
        chk("ovf_sat_set", 32'(ovf1), 32'd1);
        @(negedge clk);

        issue(1'b1, 8'hFF);
        chk("clear_ff_done", 32'(done0), 32'd1);
        chk("clear_ff_acc", {20'b0, a2_0, a1_0, a0_0}, 32'h000);
        chk("clear_ff_ovf", 32'(ovf0), 32'd0);
        chk("clear_ff_err", 32'(err0), 32'd0);
        @(negedge clk);

        issue(1'b0, 8'h12);
        wait_done("latency_12", 3);
        @(negedge clk);
        issue(1'b0, 8'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_midadd_ready", 32'(rdy0), 32'd1);
        chk("rst_midadd_acc", {20'b0, a2_0, a1_0, a0_0}, 32'h000);
        chk("rst_midadd_ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rst_midadd_no_done", 32'(done0), 32'd0);
            @(negedge clk);
        end

        in_valid = 1'b1;
        in_clr   = 1'b0;
        in_data  = 8'h12;
        last     = -1;
        n_acc    = 0;
        for (int c = 0; c < 40; c++) begin
            acc_now = rdy0;
            @(negedge clk);
            if (acc_now) begin
                if (last >= 0) chk("accept_interval", 32'(c - last), 32'd5);
                last = c;
                n_acc++;
                in_data = (in_data == 8'h12) ? 8'h34 : 8'h12;
            end
        end
        in_valid = 1'b0;
        chk("accept_count", 32'(n_acc), 32'd8);

        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) in_data = 8'($urandom);
            else in_data = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rst = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
